// File: rtl/serial_adder_sched.sv
// Two-requester round-robin scheduler around a single bit-serial full adder (LSB first).
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             req0_sub,
  input  logic             req1_sub,
  output logic             res_sub,
`endif
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             grant;
  logic             accept;
  logic             sub_sel;
  logic             s_bit;
  logic [WIDTH-1:0] a_sel, b_sel;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
  assign sub_sel = grant ? req1_sub : req0_sub;
  assign res_sub = sub_q;
`else
  assign sub_sel = 1'b0;
`endif

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state_q == StIdle) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign a_sel      = grant ? req1_a : req0_a;
  assign b_sel      = grant ? req1_b : req0_b;

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    s_bit        = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d        = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_sh_d       = a_sel;
          // Subtract as A + ~B + 1.
          b_sh_d       = sub_sel ? ~b_sel : b_sel;
          carry_d      = sub_sel;
          cnt_d        = '0;
          id_d         = grant;
          last_grant_d = grant;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d        = sub_sel;
`endif
          state_d      = StAdd;
        end
      end
      StAdd: begin
        s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q        <= sub_d;
`endif
    end
  end

  assign res_valid = (state_q == StHold);
  assign res_sum   = sum_q;
  assign res_cout  = carry_q;
  assign res_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_adder_sched.sv
// Directed self-checking bench for serial_adder_sched (WIDTH=4).
module tb_serial_adder_sched;
  localparam int unsigned WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_ready, req1_ready;
  logic             res_valid, res_cout, res_id, busy;
  logic [WIDTH-1:0] res_sum;
  logic             res_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
  logic             req0_sub = 1'b0, req1_sub = 1'b0;
  logic             res_sub;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_sched #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
`ifdef SERIAL_ADDER_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
    .res_sub    (res_sub),
`endif
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation from requester id and check latency and result.
  task automatic do_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] es, input logic ec, input string tag);
    int cnt;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    check({tag, "_ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    check({tag, "_other_ready"}, {31'd0, id ? req0_ready : req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, "_latency"}, cnt, WIDTH);
    check({tag, "_sum"}, {28'd0, res_sum}, {28'd0, es});
    check({tag, "_cout"}, {31'd0, res_cout}, {31'd0, ec});
    check({tag, "_id"}, {31'd0, res_id}, {31'd0, id});
    res_ready = 1'b1;
    step();
    check({tag, "_done"}, {30'd0, res_valid, busy}, 32'd0);
  endtask

  int g[4];
  int t[4];
  int n, cyc;

  initial begin
    // Reset state
    #2;
    check("rst_valid", {31'd0, res_valid}, 0);
    check("rst_sum", {28'd0, res_sum}, 0);
    check("rst_cout", {31'd0, res_cout}, 0);
    check("rst_id", {31'd0, res_id}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
    step(); step();
    reset = 1'b1;
    step();

    do_op(1'b0, 4'd3, 4'd5, 4'd8, 1'b0, "add3p5");
    do_op(1'b1, 4'd15, 4'd1, 4'd0, 1'b1, "wrap15p1");
    do_op(1'b0, 4'd15, 4'd15, 4'd14, 1'b1, "wrap15p15");
    do_op(1'b1, 4'd2, 4'd9, 4'd11, 1'b0, "add2p9");

    // Fairness: last grant is 1, so order must be 0,1,0,1 spaced WIDTH+2.
    req0_a = 4'd1; req0_b = 4'd2; req1_a = 4'd4; req1_b = 4'd4;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    #1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      if (req0_ready && req1_ready) check("fair_both_ready", 1, 0);
      if (req0_ready || req1_ready) begin
        g[n] = int'(req1_ready); t[n] = cyc; n++;
      end
      step();
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("fair_accepts", n, 4);
    check("fair_g0", g[0], 0);
    check("fair_g1", g[1], 1);
    check("fair_g2", g[2], 0);
    check("fair_g3", g[3], 1);
    for (int i = 1; i < 4; i++) check("fair_spacing", t[i] - t[i-1], WIDTH + 2);
    cyc = 0;
    while (busy && cyc < 20) begin step(); cyc++; end
    check("fair_drain", {31'd0, busy}, 0);

    // Back-pressure: hold result for 5 cycles with res_ready low.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd2;
    step();
    req0_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 20) begin step(); cyc++; end
    check("bp_latency", cyc, WIDTH);
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", {31'd0, res_valid}, 1);
      check("bp_sum", {28'd0, res_sum}, 9);
      check("bp_id", {31'd0, res_id}, 0);
      check("bp_ready_low", {30'd0, req0_ready, req1_ready}, 0);
      step();
    end
    req1_valid = 1'b0;
    res_ready = 1'b1;
    step();
    check("bp_done", {30'd0, res_valid, busy}, 0);

    // Reset mid-op, then last_grant must be back to 1.
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    step();
    req1_valid = 1'b0;
    step(); step();
    check("mid_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_valid", {31'd0, res_valid}, 0);
    check("mid_rst_sum", {28'd0, res_sum}, 0);
    check("mid_rst_cout", {31'd0, res_cout}, 0);
    check("mid_rst_id", {31'd0, res_id}, 0);
    #3;
    reset = 1'b1;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_rst_grant0", {30'd0, req0_ready, req1_ready}, 2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    do_op(1'b0, 4'd6, 4'd7, 4'd13, 1'b0, "add6p7");

`ifdef SERIAL_ADDER_SUB_EN
    req0_sub = 1'b1;
    do_op(1'b0, 4'd5, 4'd7, 4'd14, 1'b0, "sub5m7");
    do_op(1'b0, 4'd9, 4'd4, 4'd5, 1'b1, "sub9m4");
    req0_sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
